// File: rtl/rtr_rr_scheduler_pkg.sv
// Shared types and helpers for the router round-robin scheduler.
package rtr_sched_pkg;

  // Width of the target output port id carried in the top byte of a packet.
  localparam int PORT_ID_W   = 8;
  localparam int N_PORTS_DEF = 4;

  // Widest packet the target-field helper accepts.
  localparam int PKT_W_MAX   = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    POP  = 2'd2,
    DROP = 2'd3
  } sched_state_e;

  // Extracts the target port id from the top PORT_ID_W bits of a packet of width pkt_w.
  // The packet is passed zero-extended to PKT_W_MAX.
  function automatic logic [PORT_ID_W-1:0] target_field(input logic [PKT_W_MAX-1:0] pkt,
                                                        input int pkt_w);
    logic [PKT_W_MAX-1:0] shifted;
    shifted = pkt >> (pkt_w - PORT_ID_W);
    return shifted[PORT_ID_W-1:0];
  endfunction

endpackage

// File: rtl/rtr_rr_scheduler_if.sv
// Transfer-path bundle between the terminal inputs, the scheduler and the output FIFOs.
interface rtr_rr_scheduler_if #(
  parameter int pckg_sz = 40,
  parameter int N_PORTS = rtr_sched_pkg::N_PORTS_DEF
);
  logic [N_PORTS-1:0] pndng_i;
  logic [pckg_sz-1:0] Data_out_i [N_PORTS];
  logic [N_PORTS-1:0] full_o;
  logic [1:0]         Trn;
  logic               push_i;
  logic               pop_i;
  logic [pckg_sz-1:0] Data_in_i;

  // Scheduler side: drives the grant and strobes.
  modport master (
    input  pndng_i, Data_out_i, full_o,
    output Trn, push_i, pop_i, Data_in_i
  );

  // Router side: terminal inputs and output FIFOs.
  modport slave (
    output pndng_i, Data_out_i, full_o,
    input  Trn, push_i, pop_i, Data_in_i
  );
endinterface

// File: rtl/rtr_rr_scheduler_rr_pick.sv
// Rotating-priority picker: first asserted request after ptr wins.
// N_PORTS must be a power of two so the index add wraps naturally.
module rr_pick #(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0] idx;

  // Walk from lowest to highest priority so the last hit (ptr+1 side) wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rtr_rr_scheduler.sv
// Round-robin scheduler sharing one router transfer path between its terminal inputs.
// One packet per grant: PUSH to the target FIFO, then POP the source; invalid targets are dropped.
module rtr_rr_scheduler
  import rtr_sched_pkg::*;
#(
  parameter int pckg_sz = 40,
  parameter int N_PORTS = N_PORTS_DEF,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rtr_rr_scheduler_if.master   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [7:0]           drop_cnt,
  output logic                 drop_pulse
);

  localparam int IDX_W = $clog2(N_PORTS);

  sched_state_e         state_reg, state_next;
  logic [IDX_W-1:0]     ptr_reg;
  logic [IDX_W-1:0]     trn_reg;
  logic [pckg_sz-1:0]   data_reg;
  logic [CNT_W-1:0]     pkt_cnt_reg;
  logic [7:0]           drop_cnt_reg;

  logic [PORT_ID_W-1:0] tgt_arr [N_PORTS];
  logic [N_PORTS-1:0]   cand;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 win_drop;

  // An input competes if it is pending and either its target has room or the
  // target is invalid (those go straight to the drop path, no FIFO involved).
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cand
    assign tgt_arr[gi] = target_field(PKT_W_MAX'(bus.Data_out_i[gi]), pckg_sz);
    assign cand[gi]    = bus.pndng_i[gi] &&
                         ((tgt_arr[gi] >= PORT_ID_W'(N_PORTS)) ||
                          !bus.full_o[tgt_arr[gi][IDX_W-1:0]]);
  end

  rr_pick #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (cand),
    .ptr     (ptr_reg),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign win_drop = tgt_arr[gnt_idx] >= PORT_ID_W'(N_PORTS);

  // Next-state: one grant per IDLE evaluation, fixed PUSH->POP or DROP sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (gnt_vld) state_next = win_drop ? DROP : PUSH;
      PUSH:    state_next = POP;
      POP:     state_next = IDLE;
      DROP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, grant latch, rr pointer and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= IDX_W'(N_PORTS - 1);
      trn_reg      <= '0;
      data_reg     <= '0;
      pkt_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && gnt_vld) begin
        trn_reg <= gnt_idx;
        if (!win_drop) data_reg <= bus.Data_out_i[gnt_idx];
      end
      // The pointer only advances once the source is actually popped.
      if (state_reg == POP) begin
        ptr_reg     <= trn_reg;
        pkt_cnt_reg <= pkt_cnt_reg + CNT_W'(1);
      end
      if (state_reg == DROP) begin
        ptr_reg <= trn_reg;
        if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  // Strobes decode straight from the registered state, so they are one cycle each
  // and mutually exclusive by construction.
  assign bus.push_i    = (state_reg == PUSH);
  assign bus.pop_i     = (state_reg == POP) || (state_reg == DROP);
  assign bus.Trn       = 2'(trn_reg);
  assign bus.Data_in_i = data_reg;
  assign drop_pulse    = (state_reg == DROP);
  assign busy          = (state_reg != IDLE);
  assign pkt_cnt       = pkt_cnt_reg;
  assign drop_cnt      = drop_cnt_reg;

endmodule

// File: tb/tb_rtr_rr_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model of the round-robin scheduler.
module tb_rtr_rr_scheduler;
  localparam int PW = 40;
  localparam int NP = 4;
  localparam int CW = 8;  // short counter so wrap-around is reachable quickly

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy, drop_pulse;
  logic [CW-1:0] pkt_cnt;
  logic [7:0]    drop_cnt;

  rtr_rr_scheduler_if #(.pckg_sz(PW), .N_PORTS(NP)) bus ();

  rtr_rr_scheduler #(.pckg_sz(PW), .N_PORTS(NP), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Terminal input side
  logic [NP-1:0] in_pend = '0;
  logic [NP-1:0] in_full = '0;
  logic [NP-1:0] keep_pend = '0;
  logic [PW-1:0] in_pkt [NP];
  bit            rand_mode = 0;
  int            gnt_log [$];
  int            edge_n = 0;

  // Model: one pending transfer at a time, timed by edges
  bit            m_active, m_gdrop, m_pop_now;
  int            m_gedge, m_done, m_free, m_ptr, m_gidx, m_trn, m_pkt, m_drop;
  logic [PW-1:0] m_data;

  function automatic logic [PW-1:0] mk_pkt(input logic [7:0] tgt);
    return {tgt, 32'($urandom)};
  endfunction

  function automatic logic [7:0] rand_tgt();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 8'(r % NP);
    return 8'($urandom_range(NP, 255));
  endfunction

  task automatic drive();
    bus.pndng_i = in_pend;
    bus.full_o  = in_full;
    for (int j = 0; j < NP; j++) bus.Data_out_i[j] = in_pkt[j];
  endtask

  task automatic model_reset();
    m_active = 0; m_gdrop = 0; m_pop_now = 0;
    m_gedge = -10; m_done = -10; m_free = 0;
    m_ptr = NP - 1; m_gidx = 0; m_trn = 0;
    m_pkt = 0; m_drop = 0; m_data = '0;
  endtask

  // One clock: drive inputs at negedge, advance model at the edge, compare after it.
  task automatic step();
    int  e, i, t;
    bit  won, exp_push, exp_pop, exp_drop;
    @(negedge clk);
    if (rand_mode) begin
      rst     = !m_pop_now && ($urandom_range(0, 149) == 0);
      in_full = 4'($urandom & $urandom);
      for (int j = 0; j < NP; j++)
        if (!in_pend[j] && $urandom_range(0, 2) == 0) begin
          in_pend[j] = 1'b1;
          in_pkt[j]  = mk_pkt(rand_tgt());
        end
    end
    drive();
    @(posedge clk);
    #1;
    edge_n++;
    e = edge_n;
    if (rst) begin
      model_reset();
    end else if (m_active && e == m_done) begin
      m_ptr = m_gidx;
      if (m_gdrop) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_pkt = (m_pkt + 1) % (1 << CW);
      end
      m_active = 0;
      m_free   = e + 1;
      $display("txn edge %0d: input %0d %s, pkt_cnt %0d drop_cnt %0d",
               e, m_gidx, m_gdrop ? "dropped" : "transferred", m_pkt, m_drop);
      if (!keep_pend[2'(m_gidx)]) in_pend[2'(m_gidx)] = 1'b0;
    end else if (!m_active && e >= m_free) begin
      won = 0;
      for (int k = 1; k <= NP; k++) begin
        i = (m_ptr + k) % NP;
        t = int'(in_pkt[i][PW-1 -: 8]);
        if (!won && in_pend[i] && (t >= NP || !in_full[2'(t)])) begin
          won = 1; m_active = 1; m_gidx = i; m_trn = i; m_gedge = e;
          m_gdrop = (t >= NP);
          m_done  = e + (m_gdrop ? 1 : 2);
          if (!m_gdrop) m_data = in_pkt[i];
        end
      end
    end
    exp_push  = m_active && !m_gdrop && e == m_gedge;
    exp_drop  = m_active && m_gdrop && e == m_gedge;
    exp_pop   = m_active && (m_gdrop ? e == m_gedge : e == m_gedge + 1);
    m_pop_now = exp_pop;
    if (bus.push_i || drop_pulse) gnt_log.push_back(int'(bus.Trn));
    check_val("push_i",     bus.push_i, exp_push);
    check_val("pop_i",      bus.pop_i, exp_pop);
    check_val("drop_pulse", drop_pulse, exp_drop);
    check_val("busy",       busy, m_active);
    check_val("Trn",        bus.Trn, m_trn);
    check_val("Data_in_i",  bus.Data_in_i, m_data);
    check_val("pkt_cnt",    pkt_cnt, m_pkt);
    check_val("drop_cnt",   drop_cnt, m_drop);
    check_val("push_pop_excl", bus.push_i & bus.pop_i, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Let everything pending complete; a stall past the bound is a failure.
  task automatic drain();
    keep_pend = '0;
    in_full   = '0;
    for (int n = 0; n < 60 && (in_pend != '0 || m_active); n++) step();
    check_val("drain_done", {63'd0, (in_pend != '0) || m_active}, 0);
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int n;
    for (int j = 0; j < NP; j++) in_pkt[j] = '0;
    model_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Single transfer from input 2 to output 1
    in_pkt[2] = mk_pkt(8'd1);
    in_pend[2] = 1'b1;
    gnt_log.delete();
    repeat (4) step();
    check_val("single_gnt_cnt", gnt_log.size(), 1);
    check_val("single_gnt_idx", (gnt_log.size() > 0) ? gnt_log[0] : -1, 2);
    check_val("single_pkt_cnt", pkt_cnt, 1);

    // All four pending continuously: strict rotation from input 0
    do_reset();
    for (int j = 0; j < NP; j++) in_pkt[j] = mk_pkt(8'((j + 1) % NP));
    in_pend = '1;
    keep_pend = '1;
    gnt_log.delete();
    repeat (15) step();
    for (int j = 0; j < 5; j++)
      check_val("rr_order", (j < gnt_log.size()) ? gnt_log[j] : -1, exp_order[j]);
    check_val("rr_pkt_cnt", pkt_cnt, 5);
    drain();

    // Input 0 blocked by full target 3; input 1 goes first, then input 0
    in_pkt[0] = mk_pkt(8'd3);
    in_pkt[1] = mk_pkt(8'd2);
    in_pend   = 4'b0011;
    in_full   = 4'b1000;
    gnt_log.delete();
    repeat (6) step();
    in_full = '0;
    repeat (5) step();
    check_val("blk_gnt_cnt", gnt_log.size(), 2);
    check_val("blk_first",  (gnt_log.size() > 0) ? gnt_log[0] : -1, 1);
    check_val("blk_second", (gnt_log.size() > 1) ? gnt_log[1] : -1, 0);
    drain();

    // Invalid target drops, then saturation of the drop counter
    do_reset();
    in_pkt[3] = mk_pkt(8'h07);
    in_pend[3] = 1'b1;
    keep_pend[3] = 1'b1;
    step();
    check_val("drop_pop",   bus.pop_i, 1);
    check_val("drop_push",  bus.push_i, 0);
    check_val("drop_pulse1", drop_pulse, 1);
    step();
    check_val("drop_cnt1", drop_cnt, 1);
    repeat (600) step();
    check_val("drop_sat", drop_cnt, 255);
    drain();

    // Reset during PUSH: no pop, pointer back to 3, packet re-granted
    in_pkt[1] = mk_pkt(8'd0);
    in_pend[1] = 1'b1;
    drain();
    in_pkt[2] = mk_pkt(8'd3);
    in_pend[2] = 1'b1;
    n = 0;
    step();
    while (!bus.push_i && n < 6) begin
      step();
      n++;
    end
    check_val("rstpush_reached", bus.push_i, 1);
    in_pkt[0] = mk_pkt(8'd2);
    in_pend[0] = 1'b1;
    do_reset();
    check_val("rstpush_pop", bus.pop_i, 0);
    check_val("rstpush_busy", busy, 0);
    gnt_log.delete();
    drain();
    check_val("rstpush_first",  (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    check_val("rstpush_second", (gnt_log.size() > 1) ? gnt_log[1] : -1, 2);

    // Transfer counter wrap
    do_reset();
    for (int j = 0; j < NP; j++) in_pkt[j] = mk_pkt(8'(NP - 1 - j));
    in_pend = '1;
    keep_pend = '1;
    repeat (765) step();
    check_val("wrap_before", pkt_cnt, 255);
    repeat (3) step();
    check_val("wrap_after", pkt_cnt, 0);
    drain();

    // Randomized traffic, full back-pressure and occasional resets
    rand_mode = 1;
    repeat (2000) step();
    rand_mode = 0;
    rst = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
